// File: rtl/iic_target_responder_pkg.sv
// Shared types and constants for the I2C target responder and its bus monitor.
package iic_target_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } iic_state_t;

    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;
    localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/iic_target_responder_bus_monitor.sv
// Synchronises SCL/SDA and flags SCL edges plus START/STOP conditions.
module iic_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;

    // Idle bus is high, so resetting to 1 avoids phantom edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/iic_target_responder.sv
// I2C target with a small auto-incrementing register file and a host read port.
module iic_target_responder
    import iic_target_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         REG_COUNT = 16,
    parameter int         PTR_W     = 4
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_scl,
    input  logic             in_sda,
    output logic             out_sda_oe,
    output logic             out_busy,
    output logic             out_wr_stb,
    output logic [PTR_W-1:0] out_wr_addr,
    output logic [7:0]       out_wr_data,
    input  logic [PTR_W-1:0] in_host_addr,
    output logic [7:0]       out_host_data
);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    iic_bus_monitor u_mon (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .scl       (in_scl),
        .sda       (in_sda),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    iic_state_t       state;
    logic [2:0]       cnt;
    logic [7:0]       shreg;
    logic [PTR_W-1:0] ptr;
    logic             rw, ack_on;
    logic [7:0]       regs [REG_COUNT];
    logic [7:0]       byte_nxt;

    assign byte_nxt      = {shreg[6:0], sda_s};
    assign out_host_data = regs[in_host_addr];

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            ack_on      <= 1'b0;
            out_sda_oe  <= 1'b0;
            out_busy    <= 1'b0;
            out_wr_stb  <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            out_wr_stb <= 1'b0;
            if (start_det) begin
                state      <= ADDR;
                cnt        <= '0;
                ack_on     <= 1'b0;
                out_busy   <= 1'b1;
                out_sda_oe <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                out_busy   <= 1'b0;
                out_sda_oe <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WR_DATA: if (scl_rise) begin
                        shreg <= byte_nxt;
                        cnt   <= cnt + 3'd1;
                        if (cnt == LAST_BIT) begin
                            ack_on <= 1'b0;
                            if (state == ADDR) begin
                                rw    <= byte_nxt[0];
                                state <= (byte_nxt[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                            end else if (state == PTR) begin
                                ptr   <= byte_nxt[PTR_W-1:0];
                                state <= PTR_ACK;
                            end else begin
                                regs[ptr]   <= byte_nxt;
                                out_wr_stb  <= 1'b1;
                                out_wr_addr <= ptr;
                                out_wr_data <= byte_nxt;
                                ptr         <= ptr + 1'b1;
                                state       <= WR_ACK;
                            end
                        end
                    end
                    // First fall after the byte pulls SDA low; the next fall ends the ACK.
                    ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on     <= 1'b1;
                            out_sda_oe <= 1'b1;
                        end else begin
                            ack_on <= 1'b0;
                            cnt    <= '0;
                            if (state == ADDR_ACK && rw) begin
                                state      <= RD_DATA;
                                shreg      <= regs[ptr];
                                out_sda_oe <= ~regs[ptr][7];
                            end else begin
                                state      <= (state == ADDR_ACK) ? PTR : WR_DATA;
                                out_sda_oe <= 1'b0;
                            end
                        end
                    end
                    // cnt counts bits already clocked out, so the next bit is shreg[7-cnt].
                    RD_DATA: begin
                        if (scl_fall) out_sda_oe <= ~shreg[~cnt];
                        if (scl_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == LAST_BIT) begin
                                ptr   <= ptr + 1'b1;
                                state <= RD_ACK;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_fall) out_sda_oe <= 1'b0;
                        if (scl_rise) begin
                            if (sda_s == IIC_ACK) begin
                                state <= RD_DATA;
                                shreg <= regs[ptr];
                                cnt   <= '0;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: out_sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: doc/iic_target_responder.md
Name: iic_target_responder

Overview:
- I2C target (slave) for the IICProxy initiator; the other end of the same two-wire bus.
- Owns a small register file. Supports pointer-write, burst write and burst/random read with auto-increment.
- Sits beside IICProxy in simulation benches, and in the design as an on-chip test target reachable over the same SCL/SDA nets.
- No clock stretching; all bus timing is taken from the initiator.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- REG_COUNT, 16, number of 8-bit registers (power of two, 2..256).
- PTR_W, 4, pointer width, equal to log2(REG_COUNT).

Ports:
- in_clk  input  1  system clock; at least 8x SCL.
- in_rst_n  input  1  reset, asynchronous assert, active-low.
- in_scl  input  1  bus SCL (resolved level).
- in_sda  input  1  bus SDA (resolved level).
- out_sda_oe  output  1  1 = pull SDA low; 0 = release (open drain).
- out_busy  output  1  high from START to STOP, addressed or not.
- out_wr_stb  output  1  one-cycle pulse when a register is written over the bus.
- out_wr_addr  output  PTR_W  register index of the write.
- out_wr_data  output  8  data written.
- in_host_addr  input  PTR_W  host-side read index.
- out_host_data  output  8  reg[in_host_addr], combinational.

Behaviour:
- Reset: all registers 0, pointer 0, state IDLE. out_sda_oe=0, out_busy=0, out_wr_stb=0, out_wr_addr=0, out_wr_data=0.
- Input sync: in_scl and in_sda each pass through a 2-flop synchroniser plus one history flop. Edges are detected on the synchronised signals.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in any state and take priority over bit processing.
- START or repeated START: go to ADDR, clear the bit counter, set out_busy, release SDA.
- STOP: go to IDLE, clear out_busy, release SDA. The pointer is retained.
- Bit sampling: on SCL rising edge; MSB first; 3-bit counter.
- Driving SDA: out_sda_oe is updated on the cycle after an SCL falling edge, so it is always stable while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: after 8 bits, compare bits[7:1] with DEV_ADDR. Match goes to ADDR_ACK. Mismatch goes to IGNORE, with SDA released until STOP or START.
  - ADDR_ACK: drive low for one SCL period. If R/W=0, go to PTR; if R/W=1, go to RD_DATA and load the shift register with reg[ptr].
  - PTR: after 8 bits, ptr = byte[PTR_W-1:0] (upper bits discarded), then PTR_ACK, then WR_DATA.
  - WR_DATA: after 8 bits, write reg[ptr], pulse out_wr_stb the same cycle with the old ptr, then WR_ACK. ptr = ptr+1 mod REG_COUNT.
  - RD_DATA: drive the inverse of each shift bit (0 drives low, 1 releases). After 8 bits, release SDA and go to RD_ACK. ptr increments when the byte completes.
  - RD_ACK: sample the initiator's bit on SCL rise. Low (ACK) loads reg[ptr] and returns to RD_DATA. High (NACK) goes to IGNORE.
- Pointer wrap: REG_COUNT-1 wraps to 0 on both write and read.
- Repeated START after PTR_ACK: the pointer is kept, which gives a random read.
- Early STOP or START mid-byte: the partial byte is discarded and no register is written.
- Reset asserted mid-transfer: immediate release of SDA. Bus activity is ignored until the next START after reset is released.
- Host read port has zero latency and reflects a write on the cycle after out_wr_stb.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - constants IIC_ACK=0 and IIC_NACK=1;
  - the bits-per-byte constant 8.
- One natural sub-module, iic_bus_monitor: synchronisers plus scl_rise, scl_fall, start_det and stop_det pulses. It is reusable by IICProxy-side checkers.

Test Plan:
- Write 0xA0, 0x03, 0x5A, STOP -> ACK on all three bytes; out_wr_stb once with addr 3, data 0x5A; out_host_data at addr 3 reads 0x5A.
- Burst write 0xA0, 0x0E, 0x11, 0x22, 0x33 -> regs 14=0x11, 15=0x22, 0=0x33 (wrap); ptr ends at 1.
- Random read: 0xA0, 0x0E, repeated START, 0xA1, initiator ACK then NACK -> SDA carries 0x11 then 0x22; SDA released after NACK.
- Address 0xA2 -> NACK (SDA never driven), no out_wr_stb, out_busy high until STOP.
- STOP after 4 bits of a data byte -> no register write, state IDLE, out_busy=0.
- in_rst_n pulsed low during RD_DATA with SDA driven -> out_sda_oe=0 immediately; registers cleared; next full transaction succeeds.
